pipe_adder_sv: RTL
==================

Name: pipe_adder_sv

Overview:
- Parametrised, carry-segmented pipelined adder/subtractor with valid/ready flow control.
- Splits W-bit operands into S chunks of W/S bits and adds one chunk per pipeline stage, carry rippling stage to stage.
- Operand skew and result de-skew are handled internally.
- Accepts one operation per clock at full throughput and sits between register-sliced datapath blocks needing wide adds at high clock rate.

Parameters:
- W, 32, operand/result width in bits; must be a multiple of S.
- S, 4, number of pipeline stages (chunks); 1 <= S <= W; chunk width C = W/S.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous reset, active-high.
- valid_in  input  1  operand set on x_0/x_1/c_in/sub is valid.
- ready_in  output  1  block can accept an operand set this cycle.
- sub  input  1  0: add; 1: invert x_0 before adding.
- c_in  input  1  carry into bit 0.
- x_0  input  W  operand 0.
- x_1  input  W  operand 1.
- valid_out  output  1  y/c_out/ovf hold a valid result.
- ready_out  input  1  downstream accepts result this cycle.
- y  output  W  sum.
- c_out  output  1  carry out of bit W-1.
- ovf  output  1  signed overflow of the W-bit result.

Behaviour:
- Arithmetic:
  - sub=0: {c_out,y} = x_1 + x_0 + c_in.
  - sub=1: {c_out,y} = x_1 + ~x_0 + c_in, so c_in=1 gives true x_1 - x_0.
  - Full (W+1)-bit result, no truncation beyond c_out.
  - ovf = carry into MSB XOR c_out.
  - The result must be bit-exact with the single-cycle formula for every W, S.
- Transfer rules:
  - Input transfer occurs when valid_in & ready_in at a rising edge.
  - Output transfer occurs when valid_out & ready_out.
- Pipeline:
  - Each of S stages holds a valid bit, the completed low result chunks, the remaining unprocessed operand chunks and one carry bit.
  - Stage k adds chunk k (bits k*C+C-1 : k*C) of x_1 and the effective x_0 plus the incoming carry.
  - Stage S-1 registers drive y, c_out, ovf and valid_out directly; there is no combinational path from inputs to outputs.
- Flow control:
  - Global enable en = ready_out | ~valid_out.
  - ready_in = en, combinational from ready_out and valid_out only; it must never depend on valid_in.
  - When en=1, all stages advance one step and stage 0 captures the input, with valid = valid_in.
  - When en=0, all stage registers hold, including valid bits and data.
  - Bubbles are not collapsed; they travel with the pipe.
- Latency and throughput:
  - Exactly S cycles from input transfer to valid_out when there is no backpressure.
  - Throughput is 1 result per cycle.
- Stall:
  - While valid_out=1 and ready_out=0, y/c_out/ovf/valid_out remain stable.
  - ready_in=0 during a stall; operands presented then are not captured.
- Reset:
  - rst=1 asynchronously clears all stage valid bits, data and carries to 0.
  - Output reset values: valid_out=0, y=0, c_out=0, ovf=0, ready_in=1 (follows from valid_out=0).
  - Reset mid-operation discards all in-flight operations with no partial output.
  - First acceptance is possible at the first edge after rst deasserts.
- S=1 degenerates to a single registered adder with latency 1.
- Operand order: all stages' results drain in issue order, with no reordering.

Test Plan:
- Default W=32,S=4, ready_out=1: x_1=0xFFFFFFFF, x_0=0x00000001, c_in=0, sub=0 -> after 4 cycles valid_out=1, y=0x00000000, c_out=1, ovf=0; full-length carry ripple across all stages.
- sub=1, c_in=1, x_1=5, x_0=7 -> y=0xFFFFFFFE, c_out=0; then x_1=0x80000000, x_0=1 -> y=0x7FFFFFFF, c_out=1, ovf=1.
- Back-to-back stream of 100 random operand sets, valid_in=1 every cycle, ready_out=1 -> ready_in stays 1; 100 results in order, one per cycle starting at cycle 4; each matches reference model.
- Random ready_out (50%) and random valid_in with scoreboard -> no lost, duplicated or reordered results; outputs stable while valid_out=1 & ready_out=0; ready_in==(ready_out|~valid_out) every cycle.
- Assert rst for one cycle with 3 operations in flight -> valid_out=0, y=0, c_out=0, ovf=0 immediately (before next clk edge); no stale result emerges afterwards.
- Parameter sweep (W,S) = (8,1), (8,8), (16,2), (64,4), exhaustive or random -> bit-exact vs single-cycle formula; latency equals S.

Source files
------------

// File: rtl/pipe_adder_sv_if.sv
// pipe_adder_sv_if: operand/result bundle for the pipelined adder.
// The producer side drives operands and the result-accept strobe; the adder
// side returns ready_in and the registered result.
interface pipe_adder_sv_if #(
   parameter int W = 32
);
   logic         valid_in;
   logic         ready_in;
   logic         sub;
   logic         c_in;
   logic [W-1:0] x_0;
   logic [W-1:0] x_1;
   logic         valid_out;
   logic         ready_out;
   logic [W-1:0] y;
   logic         c_out;
   logic         ovf;

   modport master (
      output valid_in, sub, c_in, x_0, x_1, ready_out,
      input  ready_in, valid_out, y, c_out, ovf
   );

   modport slave (
      input  valid_in, sub, c_in, x_0, x_1, ready_out,
      output ready_in, valid_out, y, c_out, ovf
   );
endinterface

// File: rtl/pipe_adder_sv.sv
// pipe_adder_sv: carry-segmented pipelined adder/subtractor.
// A W-bit add is cut into S chunks of C = W/S bits; stage k resolves chunk k
// and hands its carry to stage k+1, so the critical path is one C-bit adder.
// Every stage carries the full operand and partial-sum words, which keeps the
// operand skew and result de-skew implicit: the low chunks of the partial sum
// fill in as the word moves down the pipe. W must be a multiple of S.
module pipe_adder_sv #(
   parameter int W = 32,
   parameter int S = 4
) (
   input  logic           clk,
   input  logic           rst,
   pipe_adder_sv_if.slave bus
);
   localparam int C  = W / S;
   // Stage S-1 never forwards operands, so operand storage stops one short
   localparam int OD = (S > 1) ? S - 1 : 1;

   logic                  en;

   logic [S-1:0]          stageValid_q, stageValid_d;
   logic [S-1:0]          stageCarry_q, stageCarry_d;
   logic [S-1:0][W-1:0]   stageSum_q, stageSum_d;
   logic [OD-1:0][W-1:0]  opA_q, opA_d;
   logic [OD-1:0][W-1:0]  opB_q, opB_d;
   logic                  ovf_q, ovf_d;

   logic [S-1:0]          srcValid;
   logic [S-1:0]          srcCarry;
   logic [S-1:0][W-1:0]   srcA;
   logic [S-1:0][W-1:0]   srcB;
   logic [S-1:0][W-1:0]   srcSum;
   logic [C:0]            chunkSum;

   // One global enable: the whole pipe moves unless a finished result is
   // stuck at the output. It deliberately ignores valid_in.
   assign en           = bus.ready_out | ~stageValid_q[S-1];
   assign bus.ready_in = en;

   assign bus.valid_out = stageValid_q[S-1];
   assign bus.y         = stageSum_q[S-1];
   assign bus.c_out     = stageCarry_q[S-1];
   assign bus.ovf       = ovf_q;

   // Each stage adds its own chunk to whatever the previous stage (or, for
   // stage 0, the input port) presents; subtraction inverts x_0 once on entry.
   always_comb begin
      srcValid     = '0;
      srcCarry     = '0;
      srcA         = '0;
      srcB         = '0;
      srcSum       = '0;
      stageValid_d = '0;
      stageCarry_d = '0;
      stageSum_d   = '0;
      opA_d        = opA_q;
      opB_d        = opB_q;
      ovf_d        = 1'b0;
      chunkSum     = '0;

      srcValid[0] = bus.valid_in;
      srcA[0]     = bus.x_1;
      srcB[0]     = bus.sub ? ~bus.x_0 : bus.x_0;
      srcSum[0]   = '0;
      srcCarry[0] = bus.c_in;
      for (int k = 1; k < S; k++) begin
         srcValid[k] = stageValid_q[k-1];
         srcA[k]     = opA_q[k-1];
         srcB[k]     = opB_q[k-1];
         srcSum[k]   = stageSum_q[k-1];
         srcCarry[k] = stageCarry_q[k-1];
      end

      for (int k = 0; k < S; k++) begin
         chunkSum = {1'b0, srcA[k][k*C +: C]} + {1'b0, srcB[k][k*C +: C]}
                  + (C+1)'(srcCarry[k]);
         stageValid_d[k]           = srcValid[k];
         stageSum_d[k]             = srcSum[k];
         stageSum_d[k][k*C +: C]   = chunkSum[C-1:0];
         stageCarry_d[k]           = chunkSum[C];
         if (k == S - 1) begin
            // carry into the MSB recovered from the MSB sum bit, xor carry out
            ovf_d = srcA[k][W-1] ^ srcB[k][W-1] ^ chunkSum[C-1] ^ chunkSum[C];
         end
      end

      for (int k = 0; k < S - 1; k++) begin
         opA_d[k] = srcA[k];
         opB_d[k] = srcB[k];
      end
   end

   // Stage registers: cleared asynchronously, advanced together on enable,
   // frozen together (valid bits included) during a stall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stageValid_q <= '0;
         stageCarry_q <= '0;
         stageSum_q   <= '0;
         opA_q        <= '0;
         opB_q        <= '0;
         ovf_q        <= 1'b0;
      end else if (en) begin
         stageValid_q <= stageValid_d;
         stageCarry_q <= stageCarry_d;
         stageSum_q   <= stageSum_d;
         opA_q        <= opA_d;
         opB_q        <= opB_d;
         ovf_q        <= ovf_d;
      end
   end
endmodule
